// File: rtl/rv32_lsu.sv
// RV32I load/store unit: decodes one request at a time, drives a word-addressed
// memory port with byte lanes, and returns extended load data or an error flag.
module rv32_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_load_data,
    input  logic        mem_valid
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_next;
    logic        r_we, w_we_next;
    logic [2:0]  r_funct3, w_funct3_next;
    logic [1:0]  r_addr_lo, w_addr_lo_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [31:0] r_mem_addr, w_mem_addr_next;
    logic [3:0]  r_mem_mask, w_mem_mask_next;
    logic        r_mem_enable, w_mem_enable_next;
    logic        r_mem_cmd, w_mem_cmd_next;
    logic [31:0] r_mem_wdata, w_mem_wdata_next;
    logic [31:0] r_rdata, w_rdata_next;
    logic        r_misalign, w_misalign_next;
    logic        r_fault, w_fault_next;

    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_req_mask;
    logic [31:0] w_req_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load_ext;

    // Request decode, evaluated directly on the request inputs while in IDLE.
    always_comb begin
        w_illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) ||
                       (req_we && (req_funct3 == 3'b100 || req_funct3 == 3'b101));
        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        w_req_mask   = 4'b1111;
        w_req_wdata  = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_req_mask  = 4'b0001 << req_addr[1:0];
                w_req_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_req_mask  = 4'b0011 << {req_addr[1], 1'b0};
                w_req_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_req_mask  = 4'b1111;
                w_req_wdata = req_wdata;
            end
        endcase
    end

    // Load extraction from the captured byte offset.
    always_comb begin
        w_lane = mem_load_data >> {r_addr_lo, 3'b000};
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load_ext = w_lane;
            3'b100:  w_load_ext = {24'd0, w_lane[7:0]};
            3'b101:  w_load_ext = {16'd0, w_lane[15:0]};
            default: w_load_ext = 32'd0;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_we_next         = r_we;
        w_funct3_next     = r_funct3;
        w_addr_lo_next    = r_addr_lo;
        w_cnt_next        = r_cnt;
        w_mem_addr_next   = r_mem_addr;
        w_mem_mask_next   = r_mem_mask;
        w_mem_enable_next = r_mem_enable;
        w_mem_cmd_next    = r_mem_cmd;
        w_mem_wdata_next  = r_mem_wdata;
        w_rdata_next      = r_rdata;
        w_misalign_next   = r_misalign;
        w_fault_next      = r_fault;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_we_next      = req_we;
                    w_funct3_next  = req_funct3;
                    w_addr_lo_next = req_addr[1:0];
                    w_rdata_next   = 32'd0;
                    if (w_illegal) begin
                        w_fault_next    = 1'b1;
                        w_misalign_next = 1'b0;
                        w_state_next    = S_RESP;
                    end else if (w_misaligned) begin
                        w_fault_next    = 1'b0;
                        w_misalign_next = 1'b1;
                        w_state_next    = S_RESP;
                    end else begin
                        w_fault_next      = 1'b0;
                        w_misalign_next   = 1'b0;
                        w_cnt_next        = 8'd0;
                        w_mem_enable_next = 1'b1;
                        w_mem_cmd_next    = req_we;
                        w_mem_addr_next   = {req_addr[31:2], 2'b00};
                        w_mem_mask_next   = w_req_mask;
                        w_mem_wdata_next  = w_req_wdata;
                        w_state_next      = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (r_we || mem_valid || (r_cnt == TIMEOUT_LAST)) begin
                    w_state_next      = S_RESP;
                    w_mem_enable_next = 1'b0;
                    w_mem_cmd_next    = 1'b0;
                    w_mem_addr_next   = 32'd0;
                    w_mem_mask_next   = 4'd0;
                    w_mem_wdata_next  = 32'd0;
                    // Data wins over a timeout landing on the same cycle.
                    if (!r_we && mem_valid) begin
                        w_rdata_next = w_load_ext;
                    end else if (!r_we) begin
                        w_fault_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_next    = S_IDLE;
                    w_rdata_next    = 32'd0;
                    w_misalign_next = 1'b0;
                    w_fault_next    = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_cnt        <= 8'd0;
            r_mem_addr   <= 32'd0;
            r_mem_mask   <= 4'd0;
            r_mem_enable <= 1'b0;
            r_mem_cmd    <= 1'b0;
            r_mem_wdata  <= 32'd0;
            r_rdata      <= 32'd0;
            r_misalign   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_we         <= w_we_next;
            r_funct3     <= w_funct3_next;
            r_addr_lo    <= w_addr_lo_next;
            r_cnt        <= w_cnt_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_mask   <= w_mem_mask_next;
            r_mem_enable <= w_mem_enable_next;
            r_mem_cmd    <= w_mem_cmd_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_rdata      <= w_rdata_next;
            r_misalign   <= w_misalign_next;
            r_fault      <= w_fault_next;
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign resp_valid     = (r_state == S_RESP);
    assign resp_rdata     = r_rdata;
    assign resp_misalign  = r_misalign;
    assign resp_fault     = r_fault;
    assign mem_addr       = r_mem_addr;
    assign mem_mask       = r_mem_mask;
    assign mem_enable     = r_mem_enable;
    assign mem_cmd        = r_mem_cmd;
    assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_rv32_lsu.sv
// Scoreboard bench for rv32_lsu: a word memory behind the mem port, and a
// byte-level reference model that predicts each response at issue time.
module tb_rv32_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_misalign, resp_fault;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic        mem_enable, mem_cmd;
    logic [31:0] mem_write_data, mem_load_data;
    logic        mem_valid;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        flt;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem_words [0:255];
    logic [7:0]  ref_bytes [0:1023];

    always #5 clk = ~clk;

    rv32_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable),
        .mem_cmd(mem_cmd), .mem_write_data(mem_write_data),
        .mem_load_data(mem_load_data), .mem_valid(mem_valid)
    );

    assign mem_load_data = mem_words[mem_addr[9:2]];
    assign mem_valid     = mem_enable && !mem_cmd && !stall;

    always @(posedge clk) begin
        if (mem_enable && mem_cmd) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem_words[mem_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Runs one request; chk_mem enables checking the mask and write data seen on the port.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic chk_mem,
                       input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                       input int hold, input string tag);
        exp_t e, got_e;
        logic illegal, mis;
        logic [31:0] w;
        logic [31:0] seen_addr, seen_wd;
        logic [3:0]  seen_mask;
        logic        seen_en;
        int lat;
        int a;
        a = int'(addr[9:0]);
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                  (we && (f3 == 3'b100 || f3 == 3'b101));
        mis = !illegal && (((f3[1:0] == 2'b01) && addr[0]) || ((f3 == 3'b010) && addr[1:0] != 2'b00));
        e.rdata = 32'd0; e.mis = mis; e.flt = illegal;
        e.lat = (illegal || mis) ? 1 : (!we && stall) ? 17 : 2;
        if (!illegal && !mis) begin
            if (!we && stall) e.flt = 1'b1;
            else if (!we) begin
                w = {ref_bytes[(a+3) & 1023], ref_bytes[(a+2) & 1023],
                     ref_bytes[(a+1) & 1023], ref_bytes[a]};
                case (f3)
                    3'b000:  e.rdata = {{24{w[7]}}, w[7:0]};
                    3'b001:  e.rdata = {{16{w[15]}}, w[15:0]};
                    3'b100:  e.rdata = {24'd0, w[7:0]};
                    3'b101:  e.rdata = {16'd0, w[15:0]};
                    default: e.rdata = w;
                endcase
            end else begin
                ref_bytes[a] = wdata[7:0];
                if (f3 != 3'b000) ref_bytes[a+1] = wdata[15:8];
                if (f3 == 3'b010) begin
                    ref_bytes[a+2] = wdata[23:16];
                    ref_bytes[a+3] = wdata[31:24];
                end
            end
        end
        sb_q.push_back(e);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        resp_ready = (hold == 0);
        @(posedge clk);
        lat = 1; seen_en = 1'b0; seen_addr = '0; seen_mask = '0; seen_wd = '0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && lat < 40) begin
            if (mem_enable) begin
                seen_en = 1'b1; seen_addr = mem_addr; seen_mask = mem_mask; seen_wd = mem_write_data;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!resp_valid) begin
            chk({tag, "_resp_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        got_e = sb_q.pop_front();
        chk({tag, "_rdata"}, resp_rdata, got_e.rdata);
        chk({tag, "_misalign"}, {31'd0, resp_misalign}, {31'd0, got_e.mis});
        chk({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, got_e.flt});
        chk({tag, "_latency"}, lat, got_e.lat);
        chk({tag, "_mem_used"}, {31'd0, seen_en}, {31'd0, !(illegal || mis)});
        chk({tag, "_req_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
        if (!(illegal || mis)) chk({tag, "_mem_addr"}, seen_addr, {addr[31:2], 2'b00});
        if (chk_mem) begin
            chk({tag, "_mask"}, {28'd0, seen_mask}, {28'd0, exp_mask});
            chk({tag, "_wdata"}, seen_wd, exp_wd);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, resp_rdata, got_e.rdata);
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_back_idle"}, {31'd0, req_ready}, 32'd1);
        $display("txn %s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h mis=%0d flt=%0d lat=%0d",
                 tag, we, f3, addr, wdata, got_e.rdata, got_e.mis, got_e.flt, lat);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = 32'd0;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'd0;
        reset = 1'b1; stall = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        txn(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 0, "sw");
        txn(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lw");
        txn(1'b1, 3'b000, 32'h201, 32'h000000A5, 1'b1, 4'b0010, 32'hA5A5A5A5, 0, "sb");
        txn(1'b0, 3'b000, 32'h201, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lb");
        txn(1'b0, 3'b100, 32'h201, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lbu");
        txn(1'b1, 3'b001, 32'h302, 32'h00008001, 1'b1, 4'b1100, 32'h80018001, 0, "sh");
        txn(1'b0, 3'b001, 32'h302, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lh");
        txn(1'b0, 3'b101, 32'h302, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lhu");
        txn(1'b0, 3'b000, 32'h107, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lb_b3");
        txn(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lw_mis");
        txn(1'b0, 3'b001, 32'h303, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lh_mis");
        txn(1'b1, 3'b100, 32'h200, 32'h0, 1'b0, 4'b0, 32'h0, 0, "sbu_ill");
        txn(1'b0, 3'b111, 32'h101, 32'h0, 1'b0, 4'b0, 32'h0, 0, "f7_ill_prio");
        stall = 1'b1;
        txn(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lw_timeout");
        stall = 1'b0;
        txn(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, 4'b0, 32'h0, 5, "lw_hold");

        // Abandon a stalled load with an asynchronous reset pulse.
        stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_mem_enable", {31'd0, mem_enable}, 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_mem_enable", {31'd0, mem_enable}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        $display("txn reset_mid_access done");
        txn(1'b0, 3'b000, 32'h105, 32'h0, 1'b0, 4'b0, 32'h0, 0, "lb_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
